fetch_sequencer: RTL and testbench

//  Sequences the program counter: decides per cycle whether PC advances, holds, or redirects.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer_redirect_arbiter.sv | 34 +++
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: FSM states, redirect sources and vectors.
package fetch_pkg;

  typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_e;

  // Encoding order is the redirect priority: a larger value wins.
  typedef enum logic [1:0] {NONE, BRANCH, JUMP, EXC} redir_src_e;

  typedef struct packed {
    redir_src_e  src;
    logic [31:0] target;
  } redir_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam redir_t      REDIR_NONE       = '{src: NONE, target: 32'h0};

  // The PC register adds 4 to whatever it loads, so every load is pre-decremented.
  function automatic logic [31:0] pre_addr(input logic [31:0] addr);
    return addr - 32'd4;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its surroundings (hazard/branch logic, imem, PC register).
interface fetch_sequencer_if;
  logic [31:0] pc_address_i;
  logic        stall_i;
  logic        branch_req_i;
  logic [31:0] branch_target_i;
  logic        jump_req_i;
  logic [31:0] jump_target_i;
  logic        exc_req_i;
  logic        halt_i;
  logic        resume_i;
  logic        imem_ready_i;
  logic        imem_req_o;
  logic        use_new_pc_o;
  logic [31:0] new_pc_o;
  logic        instr_valid_o;
  logic        flush_o;
  logic        halted_o;
  logic [31:0] epc_o;

  modport master (
    input  pc_address_i, stall_i, branch_req_i, branch_target_i, jump_req_i, jump_target_i,
           exc_req_i, halt_i, resume_i, imem_ready_i,
    output imem_req_o, use_new_pc_o, new_pc_o, instr_valid_o, flush_o, halted_o, epc_o
  );

  modport slave (
    output pc_address_i, stall_i, branch_req_i, branch_target_i, jump_req_i, jump_target_i,
           exc_req_i, halt_i, resume_i, imem_ready_i,
    input  imem_req_o, use_new_pc_o, new_pc_o, instr_valid_o, flush_o, halted_o, epc_o
  );
endinterface

// File: rtl/fetch_sequencer_redirect_arbiter.sv
// Combinational priority select (exc > jump > branch) across live requests and the pending redirect.
module redirect_arbiter
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        exc_req,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  input  redir_t      pending,
  output redir_t      live,
  output redir_t      winner
);

  always_comb begin
    live = REDIR_NONE;
    if (exc_req) begin
      live = '{src: EXC, target: EXC_VECTOR};
    end else if (jump_req) begin
      live = '{src: JUMP, target: jump_target};
    end else if (branch_req) begin
      live = '{src: BRANCH, target: branch_target};
    end

    // Ties go to the live request so the most recent target is kept.
    winner = pending;
    if (live.src != NONE && live.src >= pending.src) begin
      winner = live;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer: per cycle chooses advance, hold or redirect and drives the PC register load port.
// Optional exception support is enabled by defining FETCH_EXC_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  state_e      state_q, state_d;
  redir_t      pend_q, pend_d;
  redir_t      live, winner;
  logic        exc_live;
  logic [31:0] epc_q, epc_d;

  logic        imem_req, use_new, instr_valid, flush, halted;
  logic [31:0] new_pc;

`ifdef FETCH_EXC_EN
  assign exc_live = bus.exc_req_i;
`else
  assign exc_live = 1'b0;
`endif

  redirect_arbiter #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arbiter (
    .exc_req       (exc_live),
    .jump_req      (bus.jump_req_i),
    .jump_target   (bus.jump_target_i),
    .branch_req    (bus.branch_req_i),
    .branch_target (bus.branch_target_i),
    .pending       (pend_q),
    .live          (live),
    .winner        (winner)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    epc_d       = epc_q;
    imem_req    = 1'b0;
    use_new     = 1'b1;
    new_pc      = pre_addr(bus.pc_address_i);
    instr_valid = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;

    // An exception is accepted the cycle it is seen, even if only latched as pending.
    if (state_q != BOOT && live.src == EXC) begin
      epc_d = bus.pc_address_i;
    end

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, WAIT: begin
        imem_req = 1'b1;
        if (state_q == WAIT && !bus.imem_ready_i) begin
          pend_d = winner;
        end else if (winner.src != NONE) begin
          new_pc  = pre_addr(winner.target);
          flush   = 1'b1;
          pend_d  = REDIR_NONE;
          state_d = RUN;
        end else if (!bus.imem_ready_i) begin
          state_d = WAIT;
        end else if (bus.stall_i) begin
          state_d = RUN;
        end else if (bus.halt_i) begin
          state_d = HALT;
        end else begin
          use_new     = 1'b0;
          instr_valid = 1'b1;
          state_d     = RUN;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (live.src == EXC) begin
          new_pc  = pre_addr(live.target);
          flush   = 1'b1;
          state_d = RUN;
        end else if (bus.resume_i) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (!rst) begin
      imem_req    = 1'b0;
      use_new     = 1'b1;
      new_pc      = pre_addr(RESET_VECTOR);
      instr_valid = 1'b0;
      flush       = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pend_q  <= REDIR_NONE;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.imem_req_o    = imem_req;
  assign bus.use_new_pc_o  = use_new;
  assign bus.new_pc_o      = new_pc;
  assign bus.instr_valid_o = instr_valid;
  assign bus.flush_o       = flush;
  assign bus.halted_o      = halted;
`ifdef FETCH_EXC_EN
  assign bus.epc_o         = epc_q;
`else
  assign bus.epc_o         = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: the driver queues hand-computed expectations, a negedge monitor pops and checks.
module tb_fetch_sequencer;

  localparam logic [31:0] RV  = 32'h0040_0000;
  localparam logic [31:0] EXV = 32'h8000_0180;

  typedef struct {
    string       name;
    logic        req;
    logic        use_new;
    logic [31:0] npc;
    logic        iv;
    logic        fl;
    logic        hlt;
    logic [31:0] pc;
    logic [31:0] epc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc_q;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_epc = 32'h0;

  logic        s_stall = 0, s_br = 0, s_jp = 0, s_ex = 0, s_halt = 0, s_res = 0, s_rdy = 1;
  logic [31:0] s_bt = 0, s_jt = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural PC register: next = (use_new ? new : current) + 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RV;
    else      pc_q <= (bus.use_new_pc_o ? bus.new_pc_o : pc_q) + 32'd4;
  end
  assign bus.pc_address_i = pc_q;

  function automatic exp_t mk(input logic req, input logic use_new, input logic [31:0] npc,
                              input logic iv, input logic fl, input logic hlt,
                              input logic [31:0] pc);
    exp_t e;
    e.name = ""; e.req = req; e.use_new = use_new; e.npc = npc; e.iv = iv; e.fl = fl;
    e.hlt = hlt; e.pc = pc; e.epc = 32'h0;
    return e;
  endfunction

  function automatic exp_t adv(input logic [31:0] pc);
    return mk(1, 0, 32'h0, 1, 0, 0, pc);
  endfunction
  function automatic exp_t hold(input logic [31:0] pc, input logic req);
    return mk(req, 1, pc - 32'd4, 0, 0, 0, pc);
  endfunction
  function automatic exp_t redir(input logic [31:0] pc, input logic [31:0] npc);
    return mk(1, 1, npc, 0, 1, 0, pc);
  endfunction
  function automatic exp_t hlt(input logic [31:0] pc);
    return mk(0, 1, pc - 32'd4, 0, 0, 1, pc);
  endfunction

  task automatic apply_inputs();
    bus.stall_i = s_stall; bus.branch_req_i = s_br; bus.branch_target_i = s_bt;
    bus.jump_req_i = s_jp; bus.jump_target_i = s_jt; bus.exc_req_i = s_ex;
    bus.halt_i = s_halt; bus.resume_i = s_res; bus.imem_ready_i = s_rdy;
    s_stall = 0; s_br = 0; s_jp = 0; s_ex = 0; s_halt = 0; s_res = 0; s_rdy = 1;
    s_bt = 0; s_jt = 0;
  endtask

  task automatic go(input string nm, input exp_t e);
    @(posedge clk); #1;
    rst = 1'b1;
    apply_inputs();
    e.name = nm;
    e.epc = exp_epc;
    q.push_back(e);
  endtask

  task automatic rst_cyc(input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b0;
    apply_inputs();
    e = mk(0, 1, 32'h003F_FFFC, 0, 0, 0, RV);
    e.name = nm;
    e.epc = 32'h0;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic ok;
      e = q.pop_front();
      ok = (bus.imem_req_o === e.req) && (bus.use_new_pc_o === e.use_new) &&
           (!e.use_new || bus.new_pc_o === e.npc) && (bus.instr_valid_o === e.iv) &&
           (bus.flush_o === e.fl) && (bus.halted_o === e.hlt) && (pc_q === e.pc) &&
           (bus.epc_o === e.epc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s: got req=%b use=%b npc=%h iv=%b fl=%b hlt=%b pc=%h epc=%h ; want req=%b use=%b npc=%h iv=%b fl=%b hlt=%b pc=%h epc=%h",
                 e.name, bus.imem_req_o, bus.use_new_pc_o, bus.new_pc_o, bus.instr_valid_o,
                 bus.flush_o, bus.halted_o, pc_q, bus.epc_o, e.req, e.use_new, e.npc, e.iv,
                 e.fl, e.hlt, e.pc, e.epc);
      end
    end
  end

  initial begin
    apply_inputs();
    rst_cyc("reset0");
    rst_cyc("reset1");
    go("boot", hold(RV, 0));
    go("adv0", adv(32'h0040_0000));
    go("adv1", adv(32'h0040_0004));
    s_br = 1; s_bt = 32'h0040_0100;
    go("branch", redir(32'h0040_0008, 32'h0040_00FC));
    go("after_branch", adv(32'h0040_0100));
    s_br = 1; s_bt = 32'h0040_0200; s_jp = 1; s_jt = 32'h0040_0300;
    go("jump_beats_branch", redir(32'h0040_0104, 32'h0040_02FC));
    go("after_jump", adv(32'h0040_0300));
    // imem wait of three cycles, branch arriving in the second.
    s_rdy = 0; go("wait_enter", hold(32'h0040_0304, 1));
    s_rdy = 0; s_br = 1; s_bt = 32'h0040_0500;
    go("wait_branch", hold(32'h0040_0304, 1));
    s_rdy = 0; go("wait_hold", hold(32'h0040_0304, 1));
    go("wait_pending_apply", redir(32'h0040_0304, 32'h0040_04FC));
    go("after_pending", adv(32'h0040_0500));
    s_stall = 1; go("stall", hold(32'h0040_0504, 1));
    s_stall = 1; s_br = 1; s_bt = 32'h0040_0600;
    go("stall_vs_branch", redir(32'h0040_0504, 32'h0040_05FC));
    s_halt = 1; go("halt_enter", hold(32'h0040_0600, 1));
    go("halted0", hlt(32'h0040_0600));
    go("halted1", hlt(32'h0040_0600));
    go("halted2", hlt(32'h0040_0600));
    s_res = 1; go("resume", hlt(32'h0040_0600));
    go("resume_adv0", adv(32'h0040_0600));
    go("resume_adv1", adv(32'h0040_0604));
    // Pending: higher priority overwrites, lower is dropped, pending beats a live branch.
    s_rdy = 0; go("w2_enter", hold(32'h0040_0608, 1));
    s_rdy = 0; s_br = 1; s_bt = 32'h0040_0700; go("w2_branch", hold(32'h0040_0608, 1));
    s_rdy = 0; s_jp = 1; s_jt = 32'h0040_0800; go("w2_jump", hold(32'h0040_0608, 1));
    s_rdy = 0; s_br = 1; s_bt = 32'h0040_0900; go("w2_low_branch", hold(32'h0040_0608, 1));
    s_br = 1; s_bt = 32'h0040_0A00;
    go("w2_pending_jump_wins", redir(32'h0040_0608, 32'h0040_07FC));
    go("w2_after", adv(32'h0040_0800));
    // Live jump coincident with ready beats a pending branch.
    s_rdy = 0; go("w3_enter", hold(32'h0040_0804, 1));
    s_rdy = 0; s_br = 1; s_bt = 32'h0040_0B00; go("w3_branch", hold(32'h0040_0804, 1));
    s_jp = 1; s_jt = 32'h0040_0C00;
    go("w3_live_jump_wins", redir(32'h0040_0804, 32'h0040_0BFC));
    go("w3_after", adv(32'h0040_0C00));
    // Equal priority keeps the latest.
    s_rdy = 0; go("w4_enter", hold(32'h0040_0C04, 1));
    s_rdy = 0; s_br = 1; s_bt = 32'h0040_0D00; go("w4_br1", hold(32'h0040_0C04, 1));
    s_rdy = 0; s_br = 1; s_bt = 32'h0040_0E00; go("w4_br2", hold(32'h0040_0C04, 1));
    go("w4_latest", redir(32'h0040_0C04, 32'h0040_0DFC));
    go("w4_after", adv(32'h0040_0E00));
    s_jp = 1; s_jt = 32'h0;
    go("target_zero", redir(32'h0040_0E04, 32'hFFFF_FFFC));
    go("at_zero", adv(32'h0));
    s_br = 1; s_bt = RV; go("back_to_rv", redir(32'h0000_0004, 32'h003F_FFFC));
    go("rv_adv", adv(32'h0040_0000));
    // Reset while a redirect is pending must drop it.
    s_rdy = 0; go("w5_enter", hold(32'h0040_0004, 1));
    s_rdy = 0; s_br = 1; s_bt = 32'h0012_3400; go("w5_branch", hold(32'h0040_0004, 1));
    rst_cyc("reset_mid_wait");
    go("boot2", hold(RV, 0));
    go("boot2_adv0", adv(32'h0040_0000));
    go("boot2_adv1", adv(32'h0040_0004));
`ifdef FETCH_EXC_EN
    go("e_adv0", adv(32'h0040_0008));
    go("e_adv1", adv(32'h0040_000C));
    s_rdy = 0; go("e_wait", hold(32'h0040_0010, 1));
    s_rdy = 0; s_jp = 1; s_jt = 32'h0040_0F00; go("e_jump_pend", hold(32'h0040_0010, 1));
    s_rdy = 0; s_ex = 1; go("e_exc_pend", hold(32'h0040_0010, 1));
    exp_epc = 32'h0040_0010;
    go("e_exc_apply", redir(32'h0040_0010, EXV - 32'd4));
    go("e_handler", adv(EXV));
    s_halt = 1; go("e_halt", hold(EXV + 32'd4, 1));
    s_ex = 1; go("e_exc_in_halt", mk(0, 1, EXV - 32'd4, 0, 1, 1, EXV + 32'd4));
    exp_epc = EXV + 32'd4;
    go("e_after_halt_exc", adv(EXV));
`else
    s_ex = 1; go("exc_ignored", adv(32'h0040_0008));
    s_halt = 1; go("n_halt", hold(32'h0040_000C, 1));
    s_ex = 1; go("n_exc_in_halt", hlt(32'h0040_000C));
    s_res = 1; go("n_resume", hlt(32'h0040_000C));
    go("n_adv", adv(32'h0040_000C));
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
